// File: rtl/mem_access_ctrl.sv
// Load/store initiator for data_ram: one op per 3 cycles (IDLE/ACCESS/DONE), faults complete in 2.
// ready_o is the only backpressure; flush_i aborts any state without a done_o pulse.
module mem_access_ctrl (
  input  logic        clk,
  input  logic        rst,
  input  logic        req_i,
  input  logic [3:0]  op_i,
  input  logic [31:0] addr_i,
  input  logic [31:0] wdata_i,
  input  logic        flush_i,
  output logic        ready_o,
  output logic        done_o,
  output logic [31:0] rdata_o,
  output logic        misalign_o,
  output logic [31:0] bad_addr_o,
  output logic        llbit_o,
  output logic        mem_ce_o,
  output logic        mem_we_o,
  output logic [31:0] mem_addr_o,
  output logic [3:0]  mem_sel_o,
  output logic [31:0] mem_data_o,
  input  logic [31:0] mem_data_i
);
  localparam logic [3:0] OP_LB = 4'd0, OP_LBU = 4'd1, OP_LH = 4'd2, OP_LHU = 4'd3, OP_LW = 4'd4;
  localparam logic [3:0] OP_SB = 4'd5, OP_SH = 4'd6, OP_SW = 4'd7, OP_LL = 4'd8, OP_SC = 4'd9;

  typedef enum logic [1:0] {IDLE, ACCESS, DONE} state_e;

  state_e      state_q, state_d;
  logic [3:0]  op_q, op_d, sel_q, sel_d;
  logic [31:0] addr_q, addr_d, wdata_q, wdata_d;
  logic [31:0] rdata_q, rdata_d, bad_addr_q, bad_addr_d;
  logic        misalign_q, misalign_d, llbit_q, llbit_d;

  logic        is_byte, is_half, is_word, legal, fault, store_q, access;
  logic [3:0]  sel_in;
  logic [31:0] wdata_in, load_val;
  logic [7:0]  byte_lane;
  logic [15:0] half_lane;

  always_comb begin
    is_byte = op_i inside {OP_LB, OP_LBU, OP_SB};
    is_half = op_i inside {OP_LH, OP_LHU, OP_SH};
    is_word = op_i inside {OP_LW, OP_SW, OP_LL, OP_SC};
    legal   = op_i <= OP_SC;
    fault   = (is_half & addr_i[0]) | (is_word & (addr_i[1:0] != 2'b00));

    sel_in = 4'b0000;
    if (is_byte)      sel_in = 4'b1000 >> addr_i[1:0];
    else if (is_half) sel_in = addr_i[1] ? 4'b0011 : 4'b1100;
    else if (is_word) sel_in = 4'b1111;

    case (op_i)
      OP_SB:   wdata_in = {4{wdata_i[7:0]}};
      OP_SH:   wdata_in = {2{wdata_i[15:0]}};
      default: wdata_in = wdata_i;
    endcase

    // Big-endian: byte offset 0 lives in data[31:24]
    case (addr_q[1:0])
      2'd0:    byte_lane = mem_data_i[31:24];
      2'd1:    byte_lane = mem_data_i[23:16];
      2'd2:    byte_lane = mem_data_i[15:8];
      default: byte_lane = mem_data_i[7:0];
    endcase
    half_lane = addr_q[1] ? mem_data_i[15:0] : mem_data_i[31:16];

    case (op_q)
      OP_LB:   load_val = {{24{byte_lane[7]}}, byte_lane};
      OP_LBU:  load_val = {24'd0, byte_lane};
      OP_LH:   load_val = {{16{half_lane[15]}}, half_lane};
      OP_LHU:  load_val = {16'd0, half_lane};
      default: load_val = mem_data_i;
    endcase
    store_q = op_q inside {OP_SB, OP_SH, OP_SW, OP_SC};

    state_d    = state_q;
    op_d       = op_q;
    sel_d      = sel_q;
    addr_d     = addr_q;
    wdata_d    = wdata_q;
    rdata_d    = rdata_q;
    misalign_d = misalign_q;
    bad_addr_d = bad_addr_q;
    llbit_d    = llbit_q;

    if (flush_i) begin
      state_d    = IDLE;
      llbit_d    = 1'b0;
      rdata_d    = '0;
      misalign_d = 1'b0;
      bad_addr_d = '0;
    end else begin
      case (state_q)
        IDLE: if (req_i) begin
          op_d    = op_i;
          addr_d  = addr_i;
          sel_d   = sel_in;
          wdata_d = wdata_in;
          if (!legal || fault || (op_i == OP_SC && !llbit_q)) begin
            state_d    = DONE;
            rdata_d    = '0;
            misalign_d = legal & fault;
            bad_addr_d = (legal & fault) ? addr_i : '0;
            // A failed SC still consumes the link; a misaligned one never got that far
            if (legal && !fault && op_i == OP_SC) llbit_d = 1'b0;
          end else begin
            state_d = ACCESS;
          end
        end
        ACCESS: begin
          state_d    = DONE;
          misalign_d = 1'b0;
          bad_addr_d = '0;
          if (op_q == OP_SC)   rdata_d = 32'd1;
          else if (store_q)    rdata_d = '0;
          else                 rdata_d = load_val;
          if (op_q == OP_LL)   llbit_d = 1'b1;
          if (op_q == OP_SC)   llbit_d = 1'b0;
        end
        default: state_d = IDLE;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= IDLE;
      op_q       <= '0;
      sel_q      <= '0;
      addr_q     <= '0;
      wdata_q    <= '0;
      rdata_q    <= '0;
      misalign_q <= 1'b0;
      bad_addr_q <= '0;
      llbit_q    <= 1'b0;
    end else begin
      state_q    <= state_d;
      op_q       <= op_d;
      sel_q      <= sel_d;
      addr_q     <= addr_d;
      wdata_q    <= wdata_d;
      rdata_q    <= rdata_d;
      misalign_q <= misalign_d;
      bad_addr_q <= bad_addr_d;
      llbit_q    <= llbit_d;
    end
  end

  // ce is gated combinationally so a flush in ACCESS blocks the write on the same edge
  assign access     = (state_q == ACCESS);
  assign mem_ce_o   = access & ~flush_i;
  assign mem_we_o   = mem_ce_o & store_q;
  assign mem_addr_o = access ? {addr_q[31:2], 2'b00} : '0;
  assign mem_sel_o  = access ? sel_q : '0;
  assign mem_data_o = (access && store_q) ? wdata_q : '0;

  assign ready_o    = (state_q == IDLE);
  assign done_o     = (state_q == DONE);
  assign rdata_o    = rdata_q;
  assign misalign_o = misalign_q;
  assign bad_addr_o = bad_addr_q;
  assign llbit_o    = llbit_q;
endmodule

// File: doc/mem_access_ctrl.md
# mem_access_ctrl

Multi-cycle load/store initiator that sits between the MEM pipeline stage and `data_ram`. It accepts one memory operation per handshake and drives the RAM's chip-enable, write-enable, address, byte-select and write-data lanes. It captures and aligns read data, with sign or zero extension, and detects misaligned addresses. It also maintains the LL/SC link bit. Big-endian byte ordering throughout.

## Interface
- No parameters; data and address widths are 32 bits, matching `data_ram`.
- `clk` in 1: single clock; RAM writes occur on the same rising edge.
- `rst` in 1: synchronous, active-high reset.
- `req_i` in 1: operation request; sampled only when `ready_o`=1.
- `op_i` in 4: 0 LB, 1 LBU, 2 LH, 3 LHU, 4 LW, 5 SB, 6 SH, 7 SW, 8 LL, 9 SC, 10–15 illegal.
- `addr_i` in 32: byte address.
- `wdata_i` in 32: store data, right-justified.
- `flush_i` in 1: abort the current operation and clear the link bit.
- `ready_o` out 1: controller idle; a request is accepted this cycle.
- `done_o` out 1: one-cycle completion pulse.
- `rdata_o` out 32: load result, or the SC status word; valid while `done_o`=1.
- `misalign_o` out 1: with `done_o`, the operation faulted and no RAM access occurred.
- `bad_addr_o` out 32: faulting address; valid with `misalign_o`.
- `llbit_o` out 1: current link bit.
- `mem_ce_o`, `mem_we_o` out 1 each: RAM chip-enable and write-enable.
- `mem_addr_o` out 32: RAM address; bits [1:0] are always 0.
- `mem_sel_o` out 4: byte lanes; bit 3 is data[31:24].
- `mem_data_o` out 32: RAM write data.
- `mem_data_i` in 32: RAM read data, combinational from `mem_addr_o`.

## Operation
- FSM states: IDLE, ACCESS, DONE.
  - IDLE: `ready_o`=1. When `req_i`=1, register op, address and data, and precompute sel and fault.
    - Faulting or illegal op: go to DONE.
    - Otherwise: go to ACCESS.
  - ACCESS: RAM bus is driven for exactly this one cycle.
    - Reads: capture `mem_data_i` at the end of the cycle.
    - Writes: committed by the RAM on the closing edge.
    - Next state: DONE.
  - DONE: `done_o`=1 for one cycle, then go to IDLE.
- Misalignment rules:
  - LH, LHU, SH fault when addr[0]=1.
  - LW, SW, LL, SC fault when addr[1:0]≠0.
  - On a fault: no RAM access, `misalign_o`=1, `bad_addr_o`=addr, `rdata_o`=0, link bit unchanged.
- Illegal op: no RAM access, DONE with `rdata_o`=0 and `misalign_o`=0.
- Byte lane selection (`mem_sel_o`):
  - Byte ops: addr[1:0]=0→1000, 1→0100, 2→0010, 3→0001.
  - Half ops: addr[1]=0→1100, addr[1]=1→0011.
  - Word ops: 1111.
- Write data replication (`mem_data_o`):
  - SB: {4{wdata[7:0]}}.
  - SH: {2{wdata[15:0]}}.
  - SW, SC: wdata.
- Read extraction:
  - LB/LBU select the lane matching sel and sign- or zero-extend to 32 bits.
  - LH/LHU select [31:16] for addr[1]=0, [15:0] for addr[1]=1, and extend.
  - LW/LL take the word as-is.
- LL: word read; sets the link bit when ACCESS completes.
- SC:
  - Link bit=1: word write in ACCESS; `rdata_o`=1.
  - Link bit=0: no RAM access (skip ACCESS, IDLE→DONE); `rdata_o`=0.
  - The link bit is cleared at the end of any SC that reaches the RAM-access decision, including a failed SC.
- Outside ACCESS, all `mem_*_o` outputs are 0.
- `mem_ce_o` = (state==ACCESS) & ~`flush_i`; `mem_we_o` = `mem_ce_o` & store.
- `flush_i` (any state): next state IDLE and link bit cleared.
  - No `done_o` for the aborted operation.
  - A store flushed in ACCESS must not write, because ce is gated combinationally.
  - Flush in IDLE with `req_i`=1: the request is not accepted.

## Timing
- Reset: state IDLE, `ready_o`=1, `done_o`=0, `rdata_o`=0, `misalign_o`=0, `bad_addr_o`=0, link bit 0, all `mem_*_o`=0.
- Normal access: request in cycle N, ACCESS in N+1, `done_o` in N+2, `ready_o` again in N+3. Throughput is one operation per 3 cycles.
- Fault, illegal op, or failed SC: request in N, `done_o` in N+1.
- `rdata_o`, `misalign_o`, `bad_addr_o` are registered.
  - They hold their value after `done_o` until the next completion.
  - `rst` and `flush_i` zero them.
- `rst` has priority over `flush_i`; `flush_i` has priority over `req_i`.

## Test plan
- Reset, then SW addr 0x10 data 0x11223344, then LW 0x10.
  - Required: ACCESS drives sel 1111, we=1.
  - `done_o` 2 cycles after each request; `rdata_o`=0x11223344.
- With 0x8091A2B3 stored at 0x20, issue LB, LBU, LH, LHU at 0x21 and 0x22.
  - Required: LB@0x21→0xFFFFFF91, LBU@0x21→0x00000091, LH@0x22→0xFFFFA2B3, LHU@0x22→0x0000A2B3.
- SB 0xAB to 0x33, then LW 0x30.
  - Required: sel 0001, `mem_data_o`=0xABABABAB; only the low byte changes.
- LW at 0x42.
  - Required: `done_o` in N+1, `misalign_o`=1, `bad_addr_o`=0x42, `mem_ce_o` never asserted.
- LL 0x50, then SC 0x50 data 5.
  - Required: `rdata_o`=1, memory holds 5.
  - A second SC gives `rdata_o`=0, no write, `llbit_o`=0.
- SW 0x60 with `flush_i` asserted during ACCESS.
  - Required: `mem_ce_o`=0, memory unchanged, no `done_o`, `ready_o`=1 next cycle, `llbit_o`=0.
